// File: rtl/dpu_bridge_pkg.sv
// Shared types and constants for the host-to-DPU packet bridge.
// Holds the FSM states, command types, reply codes and opcode field positions.
package dpu_bridge_pkg;

  typedef enum logic [3:0] {
    S_OP,
    S_A2,
    S_A1,
    S_A0,
    S_LEN,
    S_DATA,
    S_ISSUE,
    S_WAIT_RSP,
    S_WAIT_DONE,
    S_REPLY
  } state_e;

  localparam logic [2:0] CMD_WRITE     = 3'd0;
  localparam logic [2:0] CMD_RUN       = 3'd1;
  localparam logic [2:0] CMD_READ      = 3'd2;
  localparam logic [2:0] CMD_SET_LAYER = 3'd3;
  localparam logic [2:0] CMD_SCALE     = 3'd5;

  localparam logic [7:0] RPL_ACK     = 8'hA5;
  localparam logic [7:0] RPL_ERR_OP  = 8'hEE;
  localparam logic [7:0] RPL_ERR_TMO = 8'hEF;
  localparam logic [2:0] RPL_DONE_HI = 3'b110;

  localparam int OP_BURST_BIT = 7;
  localparam int OP_RSV_HI    = 6;
  localparam int OP_RSV_LO    = 3;
  localparam int OP_TYPE_HI   = 2;
  localparam int OP_TYPE_LO   = 0;

  // Reserved bits set, or a burst of anything other than writes, is rejected.
  function automatic logic op_is_bad(input logic [7:0] op);
    return (op[OP_RSV_HI:OP_RSV_LO] != 4'd0) ||
           (op[OP_BURST_BIT] && (op[OP_TYPE_HI:OP_TYPE_LO] != CMD_WRITE));
  endfunction

endpackage

// File: rtl/dpu_host_bridge.sv
// Decodes host byte-stream packets into dpu_top command-bus transactions
// and returns exactly one reply byte per accepted opcode.
module dpu_host_bridge
  import dpu_bridge_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_data,
  input  logic              dpu_done,
  input  logic [4:0]        dpu_layer,
  output logic              busy
);

  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                burst_q, burst_d;
  logic [2:0]          type_q, type_d;
  logic [15:0]         addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [23:0]         addr_full;
  logic                in_fire;
  logic                cmd_fire;

  assign in_fire   = in_valid && in_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign addr_full = {addr_sh_q, in_data};

  assign in_ready  = (state_q == S_OP) || (state_q == S_A2) || (state_q == S_A1) ||
                     (state_q == S_A0) || (state_q == S_LEN) || (state_q == S_DATA);
  assign cmd_valid = (state_q == S_ISSUE);
  assign out_valid = (state_q == S_REPLY);
  assign busy      = (state_q != S_OP);
  assign cmd_type  = type_q;
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    type_d     = type_q;
    addr_sh_d  = addr_sh_q;
    addr_d     = addr_q;
    data_d     = data_q;
    len_d      = len_q;
    out_data_d = out_data_q;
    tmo_d      = '0;
    unique case (state_q)
      S_OP: if (in_fire) begin
        if (op_is_bad(in_data)) begin
          out_data_d = RPL_ERR_OP;
          state_d    = S_REPLY;
        end else begin
          burst_d = in_data[OP_BURST_BIT];
          type_d  = in_data[OP_TYPE_HI:OP_TYPE_LO];
          state_d = S_A2;
        end
      end
      S_A2: if (in_fire) begin
        addr_sh_d = {addr_sh_q[7:0], in_data};
        state_d   = S_A1;
      end
      S_A1: if (in_fire) begin
        addr_sh_d = {addr_sh_q[7:0], in_data};
        state_d   = S_A0;
      end
      S_A0: if (in_fire) begin
        addr_d  = ADDR_W'(addr_full);
        len_d   = 8'd0;
        state_d = burst_q ? S_LEN : S_DATA;
      end
      S_LEN: if (in_fire) begin
        len_d   = in_data;
        state_d = S_DATA;
      end
      S_DATA: if (in_fire) begin
        data_d  = in_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (cmd_fire) begin
        if (burst_q && (len_q != 8'd0)) begin
          len_d   = len_q - 8'd1;
          addr_d  = addr_q + 1'b1;
          state_d = S_DATA;
        end else if (!burst_q && (type_q == CMD_READ)) begin
          // A response arriving together with the handshake is not lost.
          if (rsp_valid) begin
            out_data_d = rsp_data;
            state_d    = S_REPLY;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end else if (!burst_q && (type_q == CMD_RUN)) begin
          state_d = S_WAIT_DONE;
        end else begin
          out_data_d = RPL_ACK;
          state_d    = S_REPLY;
        end
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          out_data_d = rsp_data;
          state_d    = S_REPLY;
        end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
          out_data_d = RPL_ERR_TMO;
          state_d    = S_REPLY;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: if (dpu_done) begin
        out_data_d = {RPL_DONE_HI, dpu_layer};
        state_d    = S_REPLY;
      end
      S_REPLY: if (out_valid && out_ready) state_d = S_OP;
      default: state_d = S_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OP;
      burst_q    <= 1'b0;
      type_q     <= 3'd0;
      addr_sh_q  <= 16'd0;
      addr_q     <= '0;
      data_q     <= 8'd0;
      len_q      <= 8'd0;
      out_data_q <= 8'd0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      type_q     <= type_d;
      addr_sh_q  <= addr_sh_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_dpu_host_bridge.sv
// Directed bench for dpu_host_bridge: packets in, command and reply logs
// checked against hand-computed values.
module tb_dpu_host_bridge;

  localparam int ADDR_W      = 24;
  localparam int RSP_TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic [2:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;
  logic              rsp_valid = 1'b0;
  logic [7:0]        rsp_data = 8'd0;
  logic              dpu_done = 1'b0;
  logic [4:0]        dpu_layer = 5'd0;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [34:0] cq[$];
  int          cq_edge[$];
  logic [7:0]  rq[$];
  int          rq_edge[$];

  dpu_host_bridge #(.ADDR_W(ADDR_W), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dpu_done(dpu_done), .dpu_layer(dpu_layer), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      cq.push_back({cmd_type, cmd_addr, cmd_data});
      cq_edge.push_back(cyc + 1);
      $display("cmd  type=%0d addr=%06h data=%02h edge=%0d", cmd_type, cmd_addr, cmd_data, cyc + 1);
    end
    if (!rst && out_valid && out_ready) begin
      rq.push_back(out_data);
      rq_edge.push_back(cyc + 1);
      $display("rply data=%02h edge=%0d", out_data, cyc + 1);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 2000) begin
      tick(1);
      n++;
    end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[]);
    foreach (p[i]) send_byte(p[i]);
  endtask

  task automatic wait_reply(input string tag, input int limit);
    int n = 0;
    while (rq.size() == 0 && n < limit) begin
      tick(1);
      n++;
    end
    check_eq(tag, rq.size(), 1);
  endtask

  function automatic logic [7:0] rq0();
    return (rq.size() > 0) ? rq[0] : 8'hxx;
  endfunction

  function automatic logic [34:0] cqi(input int i);
    return (cq.size() > i) ? cq[i] : 35'hx;
  endfunction

  task automatic clear_logs();
    cq.delete(); cq_edge.delete(); rq.delete(); rq_edge.delete();
  endtask

  initial begin
    logic [7:0] pkt[];
    int hs;

    tick(3);
    check_eq("reset_outs", {in_ready, cmd_valid, out_valid, busy, cmd_type, cmd_addr, cmd_data, out_data},
             {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'd0, 8'd0, 8'd0});
    rst = 1'b0;
    tick(2);

    // Single write
    clear_logs();
    pkt = '{8'h00, 8'h02, 8'h40, 8'h00, 8'h5A};
    send_pkt(pkt);
    wait_reply("wr_nrep", 50);
    check_eq("wr_ncmd", cq.size(), 1);
    check_eq("wr_cmd", cqi(0), {3'd0, 24'h024000, 8'h5A});
    check_eq("wr_rply", rq0(), 8'hA5);

    // Burst crossing the address wrap
    clear_logs();
    pkt = '{8'h80, 8'hFF, 8'hFF, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(pkt);
    wait_reply("bw_nrep", 50);
    check_eq("bw_ncmd", cq.size(), 4);
    check_eq("bw_cmd0", cqi(0), {3'd0, 24'hFFFFFE, 8'h11});
    check_eq("bw_cmd1", cqi(1), {3'd0, 24'hFFFFFF, 8'h22});
    check_eq("bw_cmd2", cqi(2), {3'd0, 24'h000000, 8'h33});
    check_eq("bw_cmd3", cqi(3), {3'd0, 24'h000001, 8'h44});
    if (cq_edge.size() == 4) check_eq("bw_rate", cq_edge[3] - cq_edge[0], 6);
    check_eq("bw_rply", rq0(), 8'hA5);
    tick(2);
    check_eq("bw_one_rply", rq.size(), 1);

    // Command backpressure
    clear_logs();
    cmd_ready = 1'b0;
    pkt = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h77};
    send_pkt(pkt);
    for (int i = 0; i < 5; i++) begin
      check_eq("cbp_hold", {cmd_valid, in_ready, cmd_type, cmd_addr, cmd_data},
               {1'b1, 1'b0, 3'd3, 24'h000001, 8'h77});
      tick(1);
    end
    cmd_ready = 1'b1;
    wait_reply("cbp_nrep", 50);
    check_eq("cbp_ncmd", cq.size(), 1);
    check_eq("cbp_rply", rq0(), 8'hA5);

    // Read with response
    clear_logs();
    pkt = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h00};
    send_pkt(pkt);
    tick(3);
    rsp_valid = 1'b1;
    rsp_data  = 8'h3C;
    tick(1);
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;
    wait_reply("rd_nrep", 50);
    check_eq("rd_cmd", cqi(0), {3'd2, 24'h000010, 8'h00});
    check_eq("rd_rply", rq0(), 8'h3C);

    // Read timeout: reply raised RSP_TIMEOUT edges after the handshake, taken one later
    clear_logs();
    send_pkt(pkt);
    wait_reply("tmo_nrep", RSP_TIMEOUT + 100);
    check_eq("tmo_rply", rq0(), 8'hEF);
    hs = (cq_edge.size() > 0) ? cq_edge[0] : 0;
    if (rq_edge.size() > 0) check_eq("tmo_lat", rq_edge[0] - hs, RSP_TIMEOUT + 1);

    // Run: done coincident with the handshake is ignored
    clear_logs();
    pkt = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    dpu_done  = 1'b1;
    dpu_layer = 5'd9;
    tick(1);
    dpu_done  = 1'b0;
    dpu_layer = 5'd0;
    tick(20);
    check_eq("run_early", {rq.size(), busy}, {32'd0, 1'b1});
    tick(28);
    dpu_done  = 1'b1;
    dpu_layer = 5'd7;
    tick(1);
    dpu_done  = 1'b0;
    dpu_layer = 5'd0;
    wait_reply("run_nrep", 20);
    check_eq("run_rply", rq0(), 8'hC7);

    // Bad opcodes
    clear_logs();
    send_byte(8'h48);
    wait_reply("eop_nrep", 20);
    check_eq("eop_rply", rq0(), 8'hEE);
    check_eq("eop_ncmd", cq.size(), 0);
    clear_logs();
    send_byte(8'h82);
    wait_reply("ebr_nrep", 20);
    check_eq("ebr_rply", rq0(), 8'hEE);
    check_eq("ebr_ncmd", cq.size(), 0);

    // Reply backpressure
    clear_logs();
    out_ready = 1'b0;
    pkt = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h33};
    send_pkt(pkt);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      check_eq("obp_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 8'hA5});
      tick(1);
    end
    out_ready = 1'b1;
    wait_reply("obp_nrep", 20);

    // Asynchronous reset mid-burst
    clear_logs();
    pkt = '{8'h80, 8'h00, 8'h00, 8'h20, 8'h07, 8'hAA, 8'hBB};
    send_pkt(pkt);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_outs", {in_ready, cmd_valid, out_valid, busy, cmd_type, cmd_addr, cmd_data, out_data},
             {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 24'd0, 8'd0, 8'd0});
    tick(2);
    rst = 1'b0;
    tick(20);
    check_eq("arst_norep", rq.size(), 0);
    clear_logs();
    pkt = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h66};
    send_pkt(pkt);
    wait_reply("post_nrep", 50);
    check_eq("post_cmd", cqi(0), {3'd0, 24'h000005, 8'h66});
    check_eq("post_rply", rq0(), 8'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dpu_host_bridge.md
Name: dpu_host_bridge

Overview:
- Byte-stream packet decoder sitting directly upstream of dpu_top; converts host packets (UART or DMA byte stream) into dpu_top command-bus transactions.
- Returns exactly one reply byte per packet: read data, ack, run-complete status, or error.
- Supports burst writes so weight, bias and fmap images load without per-byte headers.

Parameters:
- ADDR_W, 24, width of cmd_addr; burst addresses wrap modulo 2^ADDR_W.
- RSP_TIMEOUT, 1024, cycles to wait for rsp_valid after a read handshake before replying with an error.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  host byte valid.
- in_ready  out  1  bridge accepts byte.
- in_data  in  8  host byte.
- out_valid  out  1  reply byte valid.
- out_ready  in  1  host accepts reply.
- out_data  out  8  reply byte.
- cmd_valid  out  1  command to dpu_top.
- cmd_ready  in  1  dpu_top accepts command.
- cmd_type  out  3  0 write, 1 run, 2 read, 3 set_layer, 5 scale; others passed through.
- cmd_addr  out  ADDR_W  command address.
- cmd_data  out  8  command data.
- rsp_valid  in  1  read response pulse.
- rsp_data  in  8  read response byte.
- dpu_done  in  1  layer-complete pulse.
- dpu_layer  in  5  current_layer from dpu_top.
- busy  out  1  high whenever state is not S_OP.

Behaviour:
- Reset, asynchronous: state S_OP.
  - in_ready=1; cmd_valid=0; out_valid=0.
  - cmd_type, cmd_addr, cmd_data, out_data = 0; busy=0; timeout counter=0.
- Reset mid-packet discards all partial state; no command or reply is emitted.
- Byte transfer occurs on a posedge with in_valid&&in_ready. Reply transfer occurs on a posedge with out_valid&&out_ready.

Packet format:
- byte0 = opcode: bit7 = burst, bits6:3 reserved (must be 0), bits2:0 = cmd_type.
- bytes1-3 = address, MSB first; upper bits beyond ADDR_W are dropped.
- Non-burst: byte4 = data.
- Burst: byte4 = LEN (count-1, so 1..256 bytes), followed by LEN+1 data bytes.

State machine:
- S_OP: take opcode.
  - Reserved bits nonzero, or burst with cmd_type!=0: go to S_REPLY with 0xEE; no cmd issued, no further bytes consumed.
  - Otherwise go to S_A2.
- S_A2 -> S_A1 -> S_A0: take address bytes.
- S_A0 -> S_LEN if burst, else S_DATA.
- S_LEN: take LEN -> S_DATA.
- S_DATA: take data byte -> S_ISSUE.
- S_ISSUE: in_ready=0; cmd_valid=1. cmd_type, cmd_addr, cmd_data stay stable until the handshake (cmd_valid&&cmd_ready at posedge). Next state:
  - burst with bytes remaining: addr+1, go to S_DATA.
  - last burst byte, or type 0/3/5/other: S_REPLY with 0xA5.
  - type 2: S_WAIT_RSP.
  - type 1: S_WAIT_DONE.
  - cmd_valid deasserts the cycle after the handshake.
- S_WAIT_RSP:
  - rsp_valid is also captured in the handshake cycle itself.
  - on capture: S_REPLY with rsp_data.
  - counter reaches RSP_TIMEOUT: S_REPLY with 0xEF.
- S_WAIT_DONE:
  - dpu_done is sampled from the cycle after the handshake; a done coincident with the handshake is ignored.
  - no timeout.
  - on done: S_REPLY with {3'b110, dpu_layer} as sampled in the done cycle.
- S_REPLY: out_valid=1 with out_data stable until accepted; in_ready=0; go to S_OP on accept.

Additional rules:
- in_ready=1 only in S_OP, S_A2, S_A1, S_A0, S_LEN and S_DATA.
- Burst throughput is one byte per 2 cycles when cmd_ready is constantly high.
- Burst address wrap: 0xFFFFFF+1 -> 0x000000 (ADDR_W=24).
- Exactly one reply per accepted opcode; a second packet is never accepted before the first reply is taken.

Decomposition:
- Package dpu_bridge_pkg holds:
  - state enum.
  - cmd_type constants CMD_WRITE=0, CMD_RUN=1, CMD_READ=2, CMD_SET_LAYER=3, CMD_SCALE=5.
  - reply codes RPL_ACK=0xA5, RPL_ERR_OP=0xEE, RPL_ERR_TMO=0xEF, RPL_DONE_HI=3'b110.
  - opcode field positions.
- Single module; no sub-module needed.

Test Plan:
- Write: bytes 00 02 40 00 5A -> one cmd handshake with type0, addr 0x024000, data 0x5A; reply 0xA5.
- Burst with wrap: bytes 80 FF FF FE 03 11 22 33 44 -> four writes at FFFFFE/FFFFFF/000000/000001 with data 11/22/33/44; single reply 0xA5.
- cmd_ready held low 5 cycles during ISSUE -> cmd fields stable and cmd_valid held; in_ready=0 throughout.
- Read: 02 00 00 10 00, rsp_valid 3 cycles after handshake with 0x3C -> reply 0x3C. Repeat with no rsp -> reply 0xEF exactly RSP_TIMEOUT cycles after handshake.
- Run: 01 00 00 00 00, dpu_done 50 cycles after handshake with dpu_layer=7 -> reply 0xC7. A done pulse in the handshake cycle alone produces no reply.
- Error and backpressure: opcode 0x48 -> reply 0xEE, no cmd_valid. out_ready low 10 cycles -> out_data stable and in_ready=0. Async rst pulse mid-burst -> outputs at reset values, no reply emitted.
